// File: rtl/mem_wb_hazard_unit_if.sv
// Signal bundle between the EX/MEM/WB pipeline registers and mem_wb_hazard_unit.
// The master side drives the pipeline fields; the slave side returns stall, read data and WB data.
interface mem_wb_hazard_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_W  = 5
);
  // Hazard detector
  logic              ex_mem_read;
  logic [REG_W-1:0]  ex_rd;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic              not_stall;

  // Data memory
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_dout;

  // Write-back selector
  logic [1:0]        wb_sel;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_branch_addr;
  logic [DATA_W-1:0] wb_link_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output ex_mem_read, ex_rd, id_rs1, id_rs2,
    output mem_addr, mem_din, mem_wren,
    output wb_sel, wb_mem_data, wb_alu_result, wb_branch_addr, wb_link_addr,
    input  not_stall, mem_dout, wb_data
  );

  modport slave (
    input  ex_mem_read, ex_rd, id_rs1, id_rs2,
    input  mem_addr, mem_din, mem_wren,
    input  wb_sel, wb_mem_data, wb_alu_result, wb_branch_addr, wb_link_addr,
    output not_stall, mem_dout, wb_data
  );
endinterface

// File: rtl/mem_wb_hazard_unit.sv
// Load-use hazard detector, 2**ADDR_W-word synchronous data memory and write-back selector.
// Define DMEM_RDW_NEW_DATA_EN for write-first read-during-write; default is read-first.
module mem_wb_hazard_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_W  = 5
) (
  input logic                  clock,
  input logic                  clear,
  mem_wb_hazard_unit_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [REG_W-1:0] ZeroReg = '0;

  logic [DATA_W-1:0] memArray [Depth];
  logic [DATA_W-1:0] memDoutQ;
  logic              loadUse;
  logic [DATA_W-1:0] wbSelData;

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    loadUse = bus.ex_mem_read && (bus.ex_rd != ZeroReg) &&
              ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  end

  assign bus.not_stall = ~loadUse;

  // Storage is never cleared; only the write is gated by clear.
  always_ff @(posedge clock) begin
    if (bus.mem_wren && !clear) begin
      memArray[bus.mem_addr] <= bus.mem_din;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      memDoutQ <= '0;
    end else begin
`ifdef DMEM_RDW_NEW_DATA_EN
      memDoutQ <= bus.mem_wren ? bus.mem_din : memArray[bus.mem_addr];
`else
      memDoutQ <= memArray[bus.mem_addr];
`endif
    end
  end

  assign bus.mem_dout = memDoutQ;

  always_comb begin
    wbSelData = bus.wb_mem_data;
    unique case (bus.wb_sel)
      2'd0:    wbSelData = bus.wb_mem_data;
      2'd1:    wbSelData = bus.wb_alu_result;
      2'd2:    wbSelData = bus.wb_branch_addr;
      2'd3:    wbSelData = bus.wb_link_addr;
      default: wbSelData = bus.wb_mem_data;
    endcase
  end

  assign bus.wb_data = wbSelData;

endmodule

// File: tb/tb_mem_wb_hazard_unit.sv
// Self-checking bench for mem_wb_hazard_unit: directed cases plus randomized traffic
// compared against an array-based memory model and rule-level hazard/mux models.
module tb_mem_wb_hazard_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned Depth  = 2 ** ADDR_W;

  logic clock = 1'b0;
  logic clear;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DATA_W-1:0] refMem [Depth];

  mem_wb_hazard_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

  mem_wb_hazard_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic refNotStall(input logic load, input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
    if (load && rd != 0 && (rd == rs1 || rd == rs2)) return 1'b0;
    return 1'b1;
  endfunction

  // Drives one clock of memory traffic, advances the model, and returns the expected dout.
  task automatic memCycle(input logic clr, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] expDout);
    clear        = clr;
    bus.mem_wren = wr;
    bus.mem_addr = a;
    bus.mem_din  = d;
    if (clr) begin
      expDout = '0;
    end else begin
`ifdef DMEM_RDW_NEW_DATA_EN
      expDout = wr ? d : refMem[a];
`else
      expDout = refMem[a];
`endif
      if (wr) refMem[a] = d;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] e;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd9;
    bus.wb_sel = 2'd2; bus.wb_mem_data = 32'h1; bus.wb_alu_result = 32'h2;
    bus.wb_branch_addr = 32'h1234_5678; bus.wb_link_addr = 32'h4;
    memCycle(1'b1, 1'b0, 8'h00, 32'h0, e);
    memCycle(1'b1, 1'b0, 8'h00, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== 32'h0) begin
      testsFailed++;
      $display("FAIL reset_dout got=%h exp=%h", bus.mem_dout, 32'h0);
    end
    testsRun++;
    if (bus.not_stall !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_not_stall got=%b exp=0", bus.not_stall);
    end
    testsRun++;
    if (bus.wb_data !== 32'h1234_5678) begin
      testsFailed++;
      $display("FAIL reset_wb_data got=%h exp=12345678", bus.wb_data);
    end
    clear = 1'b0;
  endtask

  task automatic test_preload();
    logic [DATA_W-1:0] e;
    for (int i = 0; i < int'(Depth); i++) begin
      memCycle(1'b0, 1'b1, ADDR_W'(i), $urandom(), e);
    end
  endtask

  task automatic test_hazard();
    logic [REG_W-1:0] ld [3] = '{5'd5, 5'd0, 5'd7};
    logic exp;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd0; #1;
    testsRun++;
    if (bus.not_stall !== 1'b0) begin
      testsFailed++;
      $display("FAIL hazard_rs1 got=%b exp=0", bus.not_stall);
    end
    bus.ex_rd = 5'd0; #1;
    testsRun++;
    if (bus.not_stall !== 1'b1) begin
      testsFailed++;
      $display("FAIL hazard_rd_zero got=%b exp=1", bus.not_stall);
    end
    bus.ex_mem_read = 1'b0; bus.ex_rd = ld[2]; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd7; #1;
    testsRun++;
    if (bus.not_stall !== 1'b1) begin
      testsFailed++;
      $display("FAIL hazard_no_load got=%b exp=1", bus.not_stall);
    end
    bus.ex_mem_read = 1'b1; #1;
    testsRun++;
    if (bus.not_stall !== 1'b0) begin
      testsFailed++;
      $display("FAIL hazard_rs2 got=%b exp=0", bus.not_stall);
    end
    for (int i = 0; i < 200; i++) begin
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_rd  = REG_W'($urandom_range(0, 3));
      bus.id_rs1 = REG_W'($urandom_range(0, 3));
      bus.id_rs2 = REG_W'($urandom_range(0, 3));
      #1;
      exp = refNotStall(bus.ex_mem_read, bus.ex_rd, bus.id_rs1, bus.id_rs2);
      testsRun++;
      if (bus.not_stall !== exp) begin
        testsFailed++;
        $display("FAIL hazard_rand rd=%0d rs1=%0d rs2=%0d ld=%b got=%b exp=%b", bus.ex_rd,
                 bus.id_rs1, bus.id_rs2, bus.ex_mem_read, bus.not_stall, exp);
      end
    end
    bus.ex_mem_read = 1'b0;
  endtask

  task automatic test_mem_rw();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] old11;
    old11 = refMem[8'h11];
    memCycle(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, e);
    memCycle(1'b0, 1'b0, 8'h10, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== 32'hDEAD_BEEF) begin
      testsFailed++;
      $display("FAIL mem_read_back got=%h exp=deadbeef", bus.mem_dout);
    end
    memCycle(1'b0, 1'b0, 8'h11, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== old11) begin
      testsFailed++;
      $display("FAIL mem_neighbour got=%h exp=%h", bus.mem_dout, old11);
    end
  endtask

  task automatic test_rdw();
    logic [DATA_W-1:0] e;
    memCycle(1'b0, 1'b1, 8'h20, 32'h1, e);
    memCycle(1'b0, 1'b1, 8'h20, 32'h2, e);
    testsRun++;
`ifdef DMEM_RDW_NEW_DATA_EN
    if (bus.mem_dout !== 32'h2) begin
      testsFailed++;
      $display("FAIL rdw_same_edge got=%h exp=2", bus.mem_dout);
    end
`else
    if (bus.mem_dout !== 32'h1) begin
      testsFailed++;
      $display("FAIL rdw_same_edge got=%h exp=1", bus.mem_dout);
    end
`endif
    memCycle(1'b0, 1'b0, 8'h20, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== 32'h2) begin
      testsFailed++;
      $display("FAIL rdw_next_read got=%h exp=2", bus.mem_dout);
    end
  endtask

  task automatic test_clear_write();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] old30;
    old30 = refMem[8'h30];
    memCycle(1'b0, 1'b0, 8'h10, 32'h0, e);
    memCycle(1'b1, 1'b1, 8'h30, 32'h55, e);
    testsRun++;
    if (bus.mem_dout !== 32'h0) begin
      testsFailed++;
      $display("FAIL clear_dout got=%h exp=0", bus.mem_dout);
    end
    memCycle(1'b0, 1'b0, 8'h30, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== old30) begin
      testsFailed++;
      $display("FAIL clear_write_blocked got=%h exp=%h", bus.mem_dout, old30);
    end
    memCycle(1'b0, 1'b0, 8'h10, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== 32'hDEAD_BEEF) begin
      testsFailed++;
      $display("FAIL clear_keeps_mem got=%h exp=deadbeef", bus.mem_dout);
    end
  endtask

  task automatic test_wb_mux();
    logic [DATA_W-1:0] src [4];
    src = '{32'hA, 32'hB, 32'hC, 32'hD};
    bus.wb_mem_data = src[0]; bus.wb_alu_result = src[1];
    bus.wb_branch_addr = src[2]; bus.wb_link_addr = src[3];
    for (int s = 0; s < 4; s++) begin
      bus.wb_sel = 2'(s);
      #1;
      testsRun++;
      if (bus.wb_data !== src[s]) begin
        testsFailed++;
        $display("FAIL wb_mux_sel%0d got=%h exp=%h", s, bus.wb_data, src[s]);
      end
    end
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < 4; k++) src[k] = $urandom();
      bus.wb_mem_data = src[0]; bus.wb_alu_result = src[1];
      bus.wb_branch_addr = src[2]; bus.wb_link_addr = src[3];
      bus.wb_sel = 2'($urandom_range(0, 3));
      #1;
      testsRun++;
      if (bus.wb_data !== src[bus.wb_sel]) begin
        testsFailed++;
        $display("FAIL wb_mux_rand sel=%0d got=%h exp=%h", bus.wb_sel, bus.wb_data,
                 src[bus.wb_sel]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] old00;
    old00 = refMem[8'h00];
    memCycle(1'b0, 1'b1, 8'hFF, 32'h77, e);
    memCycle(1'b0, 1'b0, 8'hFF, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== 32'h77) begin
      testsFailed++;
      $display("FAIL wrap_ff got=%h exp=77", bus.mem_dout);
    end
    memCycle(1'b0, 1'b0, 8'h00, 32'h0, e);
    testsRun++;
    if (bus.mem_dout !== old00) begin
      testsFailed++;
      $display("FAIL wrap_00 got=%h exp=%h", bus.mem_dout, old00);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e;
    for (int i = 0; i < 400; i++) begin
      memCycle(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
               ADDR_W'($urandom_range(0, 7)), $urandom(), e);
      testsRun++;
      if (bus.mem_dout !== e) begin
        testsFailed++;
        $display("FAIL mem_rand cyc=%0d addr=%h got=%h exp=%h", i, bus.mem_addr, bus.mem_dout,
                 e);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    bus.mem_wren = 1'b0; bus.mem_addr = '0; bus.mem_din = '0;
    test_reset();
    test_preload();
    test_hazard();
    test_mem_rw();
    test_rdw();
    test_clear_write();
    test_wb_mux();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
